// File: rtl/fp_special_encoder.sv
`default_nettype none
// ============================================================================
// Module   : fp_special_encoder
// Brief    : Builds the IEEE special-case result (NaN / Inf / signed zero) of
//            the FP adder from per-operand class flags. Two-stage valid/ready
//            pipeline with full backpressure and a saturating invalid counter.
// Revision : 1.0 - initial release
// ============================================================================
module fp_special_encoder #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52,
    parameter int CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        op_sub,
    input  logic [1:0]                  rm,
    input  logic                        sa,
    input  logic                        za,
    input  logic                        ia,
    input  logic                        na,
    input  logic                        sna,
    input  logic                        sb,
    input  logic                        zb,
    input  logic                        ib,
    input  logic                        nb,
    input  logic                        snb,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_special,
    output logic [EXP_W+FRAC_W:0]       out_res,
    output logic                        out_inv,
    output logic [CNT_W-1:0]            inv_count
);

    localparam int W = 1 + EXP_W + FRAC_W;

    // Decoded result kinds carried from stage 1 to stage 2
    localparam logic [2:0] c_case_none = 3'd0;
    localparam logic [2:0] c_case_qnan = 3'd1;
    localparam logic [2:0] c_case_inf  = 3'd2;
    localparam logic [2:0] c_case_zero = 3'd3;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic             s1_v_q;
    logic [2:0]       s1_code_q;
    logic             s1_sign_q;
    logic             s1_inv_q;
    logic             s2_v_q;

    logic             w_sbe;
    logic             w_esub;
    logic             w_s2_en;
    logic [2:0]       code_d;
    logic             sign_d;
    logic             inv_d;
    logic [W-1:0]     res_d;
    logic             special_d;

    // Effective sign of B after folding in the operation; esub = magnitudes subtract
    assign w_sbe  = sb ^ op_sub;
    assign w_esub = sa ^ w_sbe;

    // Stage 2 can take new data when empty or when its content leaves this cycle.
    // Stage 1 can accept when empty or when it moves into stage 2.
    assign w_s2_en  = !s2_v_q || out_ready;
    assign in_ready = !s1_v_q || !s2_v_q || out_ready;
    assign out_valid = s2_v_q;

    // Priority resolution of the special case; first matching rule wins
    always_comb begin
        code_d = c_case_none;
        sign_d = 1'b0;
        inv_d  = 1'b0;
        if (sna || snb) begin
            code_d = c_case_qnan;
            inv_d  = 1'b1;
        end else if (na || nb) begin
            code_d = c_case_qnan;
        end else if (ia && ib && w_esub) begin
            code_d = c_case_qnan;
            inv_d  = 1'b1;
        end else if (ia) begin
            code_d = c_case_inf;
            sign_d = sa;
        end else if (ib) begin
            code_d = c_case_inf;
            sign_d = w_sbe;
        end else if (za && zb) begin
            code_d = c_case_zero;
            // Exact-zero sum of opposite-signed zeros is -0 only when rounding down
            sign_d = (sa == w_sbe) ? sa : (rm == 2'b11);
        end
    end

    // Stage 1: capture the decoded case on each accepted input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_code_q <= c_case_none;
            s1_sign_q <= 1'b0;
            s1_inv_q  <= 1'b0;
        end else if (in_ready) begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                s1_code_q <= code_d;
                s1_sign_q <= sign_d;
                s1_inv_q  <= inv_d;
            end
        end
    end

    // Pack the stage-1 case into an IEEE bit pattern; qNaN is canonical, no payload
    always_comb begin
        res_d     = '0;
        special_d = (s1_code_q != c_case_none);
        case (s1_code_q)
            c_case_qnan: res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
            c_case_inf:  res_d = {s1_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            c_case_zero: res_d = {s1_sign_q, {(W-1){1'b0}}};
            default:     res_d = '0;
        endcase
    end

    // Stage 2: output register; data only changes when a valid stage-1 entry moves in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v_q      <= 1'b0;
            out_res     <= '0;
            out_special <= 1'b0;
            out_inv     <= 1'b0;
        end else if (w_s2_en) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                out_res     <= res_d;
                out_special <= special_d;
                out_inv     <= s1_inv_q;
            end
        end
    end

    // Count delivered invalid results, sticking at all ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_count <= '0;
        end else if (s2_v_q && out_ready && out_inv && (inv_count != c_cnt_max)) begin
            inv_count <= inv_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_special_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_special_encoder
// Brief    : Directed vector bench for fp_special_encoder (double precision).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_special_encoder;

    localparam logic [2:0] K_NORM = 3'd0;
    localparam logic [2:0] K_ZERO = 3'd1;
    localparam logic [2:0] K_INF  = 3'd2;
    localparam logic [2:0] K_QNAN = 3'd3;
    localparam logic [2:0] K_SNAN = 3'd4;

    localparam logic [63:0] QNAN = 64'h7FF8000000000000;
    localparam logic [63:0] PINF = 64'h7FF0000000000000;
    localparam logic [63:0] NINF = 64'hFFF0000000000000;
    localparam logic [63:0] PZER = 64'h0000000000000000;
    localparam logic [63:0] NZER = 64'h8000000000000000;

    typedef struct {
        logic        a_s;
        logic [2:0]  a_k;
        logic        b_s;
        logic [2:0]  b_k;
        logic        sub;
        logic [1:0]  rm;
        logic [63:0] res;
        logic        sp;
        logic        inv;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op_sub = 1'b0;
    logic [1:0]  rm = 2'b00;
    logic        sa = 0, za = 0, ia = 0, na = 0, sna = 0;
    logic        sb = 0, zb = 0, ib = 0, nb = 0, snb = 0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_special;
    logic [63:0] out_res;
    logic        out_inv;
    logic [7:0]  inv_count;

    int checks   = 0;
    int failures = 0;
    int inv_model = 0;

    fp_special_encoder #(.EXP_W(11), .FRAC_W(52), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .rm(rm),
        .sa(sa), .za(za), .ia(ia), .na(na), .sna(sna),
        .sb(sb), .zb(zb), .ib(ib), .nb(nb), .snb(snb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_special(out_special), .out_res(out_res),
        .out_inv(out_inv), .inv_count(inv_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp_v);
        end
    endtask

    function automatic vec_t mk(input logic as_, input logic [2:0] ak, input logic bs,
                                input logic [2:0] bk, input logic sub, input logic [1:0] r,
                                input logic [63:0] res, input logic sp, input logic inv);
        vec_t v;
        v.a_s = as_; v.a_k = ak; v.b_s = bs; v.b_k = bk; v.sub = sub; v.rm = r;
        v.res = res; v.sp = sp; v.inv = inv;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        sa = v.a_s; za = (v.a_k == K_ZERO); ia = (v.a_k == K_INF);
        na = (v.a_k == K_QNAN); sna = (v.a_k == K_SNAN);
        sb = v.b_s; zb = (v.b_k == K_ZERO); ib = (v.b_k == K_INF);
        nb = (v.b_k == K_QNAN); snb = (v.b_k == K_SNAN);
        op_sub = v.sub; rm = v.rm;
    endtask

    // Runs n transfers from the table (or n copies of one entry) with an optional
    // out_ready=0 window [stall_lo, stall_hi); checks handshake, order, latency, count.
    task automatic run(input int first, input int n, input bit same,
                       input int stall_lo, input int stall_hi, input int budget);
        int sent = 0;
        int rcv  = 0;
        int acc_cyc [$];
        int idx;
        logic exp_rdy;
        for (int cyc = 0; cyc < budget && rcv < n; cyc++) begin
            @(negedge clk);
            if (sent < n) begin
                drive(vecs[same ? first : first + sent]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(cyc >= stall_lo && cyc < stall_hi);
            #1;
            exp_rdy = !((sent - rcv) == 2 && !out_ready);
            chk($sformatf("in_ready c%0d", cyc), {63'd0, in_ready}, {63'd0, exp_rdy});
            chk($sformatf("inv_count c%0d", cyc), {56'd0, inv_count}, 64'(inv_model));
            if (out_valid && out_ready) begin
                idx = same ? first : first + rcv;
                chk($sformatf("res v%0d", idx), out_res, vecs[idx].res);
                chk($sformatf("special v%0d", idx), {63'd0, out_special}, {63'd0, vecs[idx].sp});
                chk($sformatf("inv v%0d", idx), {63'd0, out_inv}, {63'd0, vecs[idx].inv});
                if (stall_lo < 0)
                    chk($sformatf("latency v%0d", idx), 64'(cyc - acc_cyc[0]), 64'd2);
                void'(acc_cyc.pop_front());
                if (vecs[idx].inv && inv_model < 255) inv_model++;
                rcv++;
            end
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("run complete", 64'(rcv), 64'(n));
    endtask

    initial begin
        vecs[0]  = mk(0, K_INF,  0, K_INF,  1, 2'b00, QNAN, 1, 1);
        vecs[1]  = mk(1, K_INF,  0, K_ZERO, 0, 2'b00, NINF, 1, 0);
        vecs[2]  = mk(0, K_ZERO, 1, K_INF,  1, 2'b00, PINF, 1, 0);
        vecs[3]  = mk(0, K_ZERO, 0, K_ZERO, 1, 2'b00, PZER, 1, 0);
        vecs[4]  = mk(0, K_ZERO, 0, K_ZERO, 1, 2'b11, NZER, 1, 0);
        vecs[5]  = mk(1, K_ZERO, 1, K_ZERO, 0, 2'b00, NZER, 1, 0);
        vecs[6]  = mk(0, K_SNAN, 0, K_QNAN, 0, 2'b00, QNAN, 1, 1);
        vecs[7]  = mk(0, K_QNAN, 0, K_INF,  0, 2'b00, QNAN, 1, 0);
        vecs[8]  = mk(0, K_NORM, 1, K_NORM, 0, 2'b00, PZER, 0, 0);
        vecs[9]  = mk(0, K_INF,  0, K_INF,  0, 2'b00, PINF, 1, 0);
        vecs[10] = mk(0, K_INF,  1, K_INF,  0, 2'b01, QNAN, 1, 1);
        vecs[11] = mk(1, K_ZERO, 0, K_ZERO, 0, 2'b10, PZER, 1, 0);
        vecs[12] = mk(1, K_INF,  0, K_INF,  1, 2'b00, NINF, 1, 0);
        vecs[13] = mk(1, K_ZERO, 0, K_NORM, 0, 2'b11, PZER, 0, 0);
        vecs[14] = mk(1, K_QNAN, 0, K_SNAN, 1, 2'b00, QNAN, 1, 1);

        repeat (2) @(negedge clk);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset inv_count", {56'd0, inv_count}, 64'd0);
        chk("reset out_res", out_res, 64'd0);
        chk("reset out_special", {63'd0, out_special}, 64'd0);
        chk("reset out_inv", {63'd0, out_inv}, 64'd0);
        rst = 1'b0;

        // Isolated transactions: exact latency and per-case values
        for (int i = 0; i < NV; i++) run(i, 1, 1'b0, -1, -1, 20);
        @(negedge clk);
        chk("inv_count after singles", {56'd0, inv_count}, 64'd4);

        // Back-to-back stream with a 5-cycle output stall mid-stream
        run(0, 10, 1'b0, 4, 9, 100);

        // Saturation of the invalid counter
        run(6, 300, 1'b0 | 1'b1, -1, -1, 400);
        @(negedge clk);
        chk("inv_count saturated", {56'd0, inv_count}, 64'd255);

        // Asynchronous reset with both stages loaded
        @(negedge clk);
        out_ready = 1'b0;
        drive(vecs[0]);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre-reset out_valid", {63'd0, out_valid}, 64'd1);
        chk("pre-reset in_ready", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", {63'd0, out_valid}, 64'd0);
        chk("async rst inv_count", {56'd0, inv_count}, 64'd0);
        chk("async rst in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("post-rst out_valid c%0d", c), {63'd0, out_valid}, 64'd0);
            chk($sformatf("post-rst inv_count c%0d", c), {56'd0, inv_count}, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
